conv_window_scan: RTL and testbench

- Streaming 2-D convolution core for the ConvNet datapath.
- Holds a KER_SIZE x KER_SIZE kernel and computes one unsigned multiply-accumulate over a KER_SIZE x KER_SIZE pixel window each cycle.
- Also generates the (i, j) top-left window indices that scan an IMG_SIZE x IMG_SIZE image in raster order. The surrounding fetch logic uses these indices to slice the window out of image memory.

---
 rtl/conv_pkg.sv | 27 ++
 rtl/window_index_gen.sv | 41 ++++
 rtl/conv_window_scan.sv | 67 ++++++
 tb/tb_conv_window_scan.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared sizing, window/kernel packing and element access
// for the streaming convolution core.
package conv_pkg;

    localparam int IMG_SIZE  = 7;
    localparam int KER_SIZE  = 3;
    localparam int WIDTH_BIT = 8;

    localparam int N_ELEM  = KER_SIZE * KER_SIZE;
    localparam int MAX_IDX = IMG_SIZE - KER_SIZE;
    localparam int ACC_W   = 2 * WIDTH_BIT + $clog2(N_ELEM);
    localparam int VEC_W   = N_ELEM * WIDTH_BIT;

    typedef logic [WIDTH_BIT-1:0]            elem_t;
    typedef logic [N_ELEM-1:0][WIDTH_BIT-1:0] win_t;
    typedef logic [ACC_W-1:0]                acc_t;

    // Element [r][c] sits at flat index r*KER_SIZE+c.
    function automatic elem_t elemAt(
        input win_t v,
        input int   r,
        input int   c
    );
        return v[r*KER_SIZE+c];
    endfunction

endpackage

// File: rtl/window_index_gen.sv
// Raster-order top-left window index generator with
// a registered end-of-frame pulse.
module window_index_gen #(
    parameter int MAX_IDX = 4,
    parameter int W       = 8
) (
    input  logic         clock,
    input  logic         nreset,
    input  logic         en,
    output logic [W-1:0] i,
    output logic [W-1:0] j,
    output logic         frame_done
);

    localparam logic [W-1:0] LAST = W'(MAX_IDX);

    logic iLast;
    logic jLast;

    assign iLast = (i == LAST);
    assign jLast = (j == LAST);

    always_ff @(posedge clock or posedge nreset) begin
        if (nreset) begin
            i          <= '0;
            j          <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= en && iLast && jLast;
            if (en) begin
                if (!jLast) begin
                    j <= j + 1'b1;
                end else begin
                    j <= '0;
                    i <= iLast ? '0 : i + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/conv_window_scan.sv
// Window index scan plus one registered KxK unsigned MAC
// per valid window against a loadable kernel.
module conv_window_scan
    import conv_pkg::*;
(
    input  logic                 clock,
    input  logic                 nreset,
    input  logic                 en,
    output logic [WIDTH_BIT-1:0] i,
    output logic [WIDTH_BIT-1:0] j,
    output logic                 frame_done,
    input  logic                 kernel_load,
    input  logic [VEC_W-1:0]     kernel_in,
    input  logic                 win_valid,
    input  logic [VEC_W-1:0]     window_in,
    output logic [ACC_W-1:0]     conv_out,
    output logic                 out_valid
);

    win_t kernelReg;
    win_t windowVec;
    acc_t macSum;

    assign windowVec = window_in;

    window_index_gen #(
        .MAX_IDX (MAX_IDX),
        .W       (WIDTH_BIT)
    ) uIndex (
        .clock      (clock),
        .nreset     (nreset),
        .en         (en),
        .i          (i),
        .j          (j),
        .frame_done (frame_done)
    );

    // Products are 2*WIDTH_BIT wide; the tree is sized so it cannot wrap.
    always_comb begin
        macSum = '0;
        for (int r = 0; r < KER_SIZE; r++) begin
            for (int c = 0; c < KER_SIZE; c++) begin
                macSum = macSum
                       + ACC_W'(elemAt(windowVec, r, c))
                       * ACC_W'(elemAt(kernelReg, r, c));
            end
        end
    end

    // The MAC reads kernelReg, so a same-edge load only affects later windows.
    always_ff @(posedge clock or posedge nreset) begin
        if (nreset) begin
            kernelReg <= '0;
            conv_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= win_valid;
            if (win_valid) begin
                conv_out <= macSum;
            end
            if (kernel_load) begin
                kernelReg <= kernel_in;
            end
        end
    end

endmodule

// File: tb/tb_conv_window_scan.sv
// Self-checking bench: directed scenarios plus a randomized
// run against a plain-arithmetic reference model.
module tb_conv_window_scan;

    logic        clock;
    logic        nreset;
    logic        en;
    logic [7:0]  i;
    logic [7:0]  j;
    logic        frame_done;
    logic        kernel_load;
    logic [71:0] kernel_in;
    logic        win_valid;
    logic [71:0] window_in;
    logic [19:0] conv_out;
    logic        out_valid;

    int nCompared;
    int nMismatched;
    int scanPos;

    conv_window_scan dut (
        .clock       (clock),
        .nreset      (nreset),
        .en          (en),
        .i           (i),
        .j           (j),
        .frame_done  (frame_done),
        .kernel_load (kernel_load),
        .kernel_in   (kernel_in),
        .win_valid   (win_valid),
        .window_in   (window_in),
        .conv_out    (conv_out),
        .out_valid   (out_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [71:0] fill(input int v);
        logic [71:0] r;
        r = '0;
        for (int k = 0; k < 9; k++) r[k*8 +: 8] = 8'(v);
        return r;
    endfunction

    function automatic int refConv(input logic [71:0] w, input logic [71:0] ker);
        int s;
        s = 0;
        for (int k = 0; k < 9; k++) s += int'(w[k*8 +: 8]) * int'(ker[k*8 +: 8]);
        return s;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        nreset = 1'b1;
        #3;
        nCompared += 4;
        if (i !== 8'd0 || j !== 8'd0) begin
            nMismatched++;
            $display("FAIL reset_idx: i=%0d j=%0d required 0 0", i, j);
        end
        if (conv_out !== 20'd0) begin
            nMismatched++;
            $display("FAIL reset_conv: got %0d required 0", conv_out);
        end
        if (out_valid !== 1'b0) begin
            nMismatched++;
            $display("FAIL reset_valid: got %b required 0", out_valid);
        end
        if (frame_done !== 1'b0) begin
            nMismatched++;
            $display("FAIL reset_fd: got %b required 0", frame_done);
        end
        step();
        step();
        nreset = 1'b0;
        // Load all-1 kernel on the same edge as an all-2 window: old (zero) kernel applies.
        en = 1'b1;
        kernel_load = 1'b1;
        kernel_in = fill(1);
        win_valid = 1'b1;
        window_in = fill(2);
        step();
        kernel_load = 1'b0;
        nCompared += 2;
        if (conv_out !== 20'd0 || out_valid !== 1'b1) begin
            nMismatched++;
            $display("FAIL post_reset_kernel: conv=%0d v=%b required 0 1", conv_out, out_valid);
        end
        if (i !== 8'd0 || j !== 8'd1) begin
            nMismatched++;
            $display("FAIL post_reset_scan: i=%0d j=%0d required 0 1", i, j);
        end
        step();
        nCompared++;
        if (conv_out !== 20'd18) begin
            nMismatched++;
            $display("FAIL pre_reset_conv: got %0d required 18", conv_out);
        end
        // Mid-cycle asynchronous reset.
        #3;
        nreset = 1'b1;
        #1;
        nCompared++;
        if (i !== 8'd0 || j !== 8'd0 || conv_out !== 20'd0 ||
            out_valid !== 1'b0 || frame_done !== 1'b0) begin
            nMismatched++;
            $display("FAIL async_reset: i=%0d j=%0d conv=%0d v=%b fd=%b required all 0",
                     i, j, conv_out, out_valid, frame_done);
        end
        step();
        nCompared++;
        if (i !== 8'd0 || j !== 8'd0 || conv_out !== 20'd0 || out_valid !== 1'b0) begin
            nMismatched++;
            $display("FAIL reset_held: i=%0d j=%0d conv=%0d v=%b required all 0",
                     i, j, conv_out, out_valid);
        end
        nreset = 1'b0;
        en = 1'b0;
        window_in = fill(1);
        win_valid = 1'b1;
        step();
        nCompared++;
        if (conv_out !== 20'd0 || out_valid !== 1'b1) begin
            nMismatched++;
            $display("FAIL kernel_cleared: conv=%0d v=%b required 0 1", conv_out, out_valid);
        end
        win_valid = 1'b0;
        step();
        scanPos = 0;
    endtask

    task automatic test_scan();
        int fdCount;
        fdCount = 0;
        nCompared++;
        if (i !== 8'd0 || j !== 8'd0) begin
            nMismatched++;
            $display("FAIL scan_start: i=%0d j=%0d required 0 0", i, j);
        end
        en = 1'b1;
        for (int k = 0; k < 26; k++) begin
            step();
            scanPos = (scanPos + 1) % 25;
            if (frame_done === 1'b1) fdCount++;
            nCompared++;
            if (i !== 8'(scanPos / 5) || j !== 8'(scanPos % 5) ||
                frame_done !== (scanPos == 0)) begin
                nMismatched++;
                $display("FAIL scan_step%0d: i=%0d j=%0d fd=%b required %0d %0d %b",
                         k, i, j, frame_done, scanPos / 5, scanPos % 5, scanPos == 0);
            end
        end
        nCompared++;
        if (fdCount != 1) begin
            nMismatched++;
            $display("FAIL scan_fd_count: got %0d required 1", fdCount);
        end
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            nCompared++;
            if (i !== 8'd0 || j !== 8'd1 || frame_done !== 1'b0) begin
                nMismatched++;
                $display("FAIL scan_hold%0d: i=%0d j=%0d fd=%b required 0 1 0",
                         k, i, j, frame_done);
            end
        end
    endtask

    task automatic test_all_ones();
        kernel_load = 1'b1;
        kernel_in = fill(1);
        step();
        kernel_load = 1'b0;
        window_in = fill(1);
        win_valid = 1'b1;
        step();
        win_valid = 1'b0;
        nCompared++;
        if (conv_out !== 20'd9 || out_valid !== 1'b1) begin
            nMismatched++;
            $display("FAIL all_ones: conv=%0d v=%b required 9 1", conv_out, out_valid);
        end
        step();
        nCompared++;
        if (conv_out !== 20'd9 || out_valid !== 1'b0) begin
            nMismatched++;
            $display("FAIL all_ones_hold: conv=%0d v=%b required 9 0", conv_out, out_valid);
        end
    endtask

    task automatic test_max_identity();
        logic [71:0] seq;
        kernel_load = 1'b1;
        kernel_in = fill(255);
        step();
        kernel_load = 1'b0;
        window_in = fill(255);
        win_valid = 1'b1;
        step();
        win_valid = 1'b0;
        nCompared++;
        if (conv_out !== 20'd585225) begin
            nMismatched++;
            $display("FAIL max_value: got %0d required 585225", conv_out);
        end
        kernel_load = 1'b1;
        kernel_in = '0;
        kernel_in[4*8 +: 8] = 8'd1;
        step();
        kernel_load = 1'b0;
        for (int k = 0; k < 9; k++) seq[k*8 +: 8] = 8'(k + 1);
        window_in = seq;
        win_valid = 1'b1;
        step();
        win_valid = 1'b0;
        nCompared++;
        if (conv_out !== 20'd5) begin
            nMismatched++;
            $display("FAIL identity: got %0d required 5", conv_out);
        end
    endtask

    task automatic test_kernel_swap();
        kernel_load = 1'b1;
        kernel_in = fill(1);
        step();
        kernel_in = fill(2);
        window_in = fill(1);
        win_valid = 1'b1;
        step();
        kernel_load = 1'b0;
        nCompared++;
        if (conv_out !== 20'd9) begin
            nMismatched++;
            $display("FAIL swap_old: got %0d required 9", conv_out);
        end
        step();
        win_valid = 1'b0;
        nCompared++;
        if (conv_out !== 20'd18) begin
            nMismatched++;
            $display("FAIL swap_new: got %0d required 18", conv_out);
        end
    endtask

    task automatic test_back_to_back();
        kernel_load = 1'b1;
        kernel_in = fill(1);
        step();
        kernel_load = 1'b0;
        win_valid = 1'b1;
        for (int v = 1; v <= 3; v++) begin
            window_in = fill(v);
            step();
            nCompared++;
            if (conv_out !== 20'(9 * v) || out_valid !== 1'b1) begin
                nMismatched++;
                $display("FAIL stream%0d: conv=%0d v=%b required %0d 1",
                         v, conv_out, out_valid, 9 * v);
            end
        end
        win_valid = 1'b0;
        step();
    endtask

    task automatic test_random();
        logic [71:0] modelKer;
        int          expConv;
        logic        expValid;
        logic        expFd;
        kernel_load = 1'b1;
        kernel_in = '0;
        win_valid = 1'b1;
        window_in = '0;
        step();
        modelKer = '0;
        expConv = 0;
        for (int n = 0; n < 60; n++) begin
            kernel_load = ($urandom_range(0, 3) == 0);
            win_valid = ($urandom_range(0, 1) == 1);
            en = ($urandom_range(0, 2) != 0);
            for (int k = 0; k < 9; k++) begin
                kernel_in[k*8 +: 8] = 8'($urandom);
                window_in[k*8 +: 8] = 8'($urandom);
            end
            if (win_valid) expConv = refConv(window_in, modelKer);
            if (kernel_load) modelKer = kernel_in;
            expValid = win_valid;
            expFd = 1'b0;
            if (en) begin
                scanPos = (scanPos + 1) % 25;
                expFd = (scanPos == 0);
            end
            step();
            nCompared++;
            if (conv_out !== 20'(expConv) || out_valid !== expValid) begin
                nMismatched++;
                $display("FAIL rand_mac%0d: conv=%0d v=%b required %0d %b",
                         n, conv_out, out_valid, expConv, expValid);
            end
            nCompared++;
            if (i !== 8'(scanPos / 5) || j !== 8'(scanPos % 5) || frame_done !== expFd) begin
                nMismatched++;
                $display("FAIL rand_scan%0d: i=%0d j=%0d fd=%b required %0d %0d %b",
                         n, i, j, frame_done, scanPos / 5, scanPos % 5, expFd);
            end
        end
        kernel_load = 1'b0;
        win_valid = 1'b0;
        en = 1'b0;
    endtask

    initial begin
        nCompared = 0;
        nMismatched = 0;
        scanPos = 0;
        nreset = 1'b1;
        en = 1'b0;
        kernel_load = 1'b0;
        kernel_in = '0;
        win_valid = 1'b0;
        window_in = '0;
        test_reset();
        test_scan();
        test_all_ones();
        test_max_identity();
        test_kernel_swap();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
